// File: rtl/flex_fifo.sv
// Synchronous FIFO with registered-read or first-word-fall-through output,
// registered occupancy flags, sticky overflow/underflow and synchronous flush.
module flex_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [WIDTH-1:0]         din,
  input  logic                     re,
  input  logic                     flush,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH    = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_TH    = CW'(AEMPTY_TH);
  localparam bit IS_FWFT = (FWFT != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             empty_q, empty_d, full_q, full_d;
  logic             aempty_q, aempty_d, afull_q, afull_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc;

  // Acceptance uses pre-edge flags, so a full FIFO takes only the read
  // and an empty FIFO takes only the write.
  always_comb begin
    wr_acc   = we & ~full_q & ~flush;
    rd_acc   = re & ~empty_q & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        dout_d   = mem_q[rd_ptr_q];
        valid_d  = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A new error on the same edge as clear_err wins.
      ovf_d = (ovf_q & ~clear_err) | (we & full_q);
      unf_d = (unf_q & ~clear_err) | (re & empty_q);
    end
    empty_d  = (count_d == '0);
    full_d   = (count_d == FULL_CNT);
    aempty_d = (count_d <= AE_TH);
    afull_d  = (count_d >= AF_TH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  // In FWFT mode the head entry is shown directly; dout_q keeps the last
  // popped word so dout holds once the FIFO drains or is flushed.
  assign dout         = (IS_FWFT && !empty_q) ? mem_q[rd_ptr_q] : dout_q;
  assign valid        = IS_FWFT ? ~empty_q : valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = aempty_q;
  assign almost_full  = afull_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_flex_fifo.sv
// Directed plus randomized bench for flex_fifo, one registered-read and one
// FWFT instance driven in lockstep against a queue-based reference model.
module tb_flex_fifo;

  logic        clk = 1'b0;
  logic        reset, we, re, flush, clear_err;
  logic [31:0] din;

  logic [31:0] dout0, dout1;
  logic        valid0, empty0, full0, ae0, af0, ovf0, unf0;
  logic        valid1, empty1, full1, ae1, af1, ovf1, unf1;
  logic [3:0]  count0, count1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_ovf, m_unf, m_v0;
  logic [31:0] m_d0;

  always #5 clk = ~clk;

  flex_fifo #(.FWFT(0)) u0 (
    .clk(clk), .reset(reset), .we(we), .din(din), .re(re), .flush(flush),
    .clear_err(clear_err), .dout(dout0), .valid(valid0), .empty(empty0),
    .full(full0), .almost_empty(ae0), .almost_full(af0), .count(count0),
    .overflow(ovf0), .underflow(unf0));

  flex_fifo #(.FWFT(1)) u1 (
    .clk(clk), .reset(reset), .we(we), .din(din), .re(re), .flush(flush),
    .clear_err(clear_err), .dout(dout1), .valid(valid1), .empty(empty1),
    .full(full1), .almost_empty(ae1), .almost_full(af1), .count(count1),
    .overflow(ovf1), .underflow(unf1));

  task automatic chk(string ph, string nm, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s observed=%0h expected=%0h", ph, nm, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_v0  = 0;
    m_d0  = '0;
  endtask

  // One rising edge of the reference model, using the inputs present at it.
  task automatic m_step();
    int n;
    bit e, f, rd, wr;
    if (flush) begin
      q.delete();
      m_v0 = 0;
    end else begin
      n  = q.size();
      e  = (n == 0);
      f  = (n == 8);
      rd = re && !e;
      wr = we && !f;
      m_ovf = (m_ovf && !clear_err) || (we && f);
      m_unf = (m_unf && !clear_err) || (re && e);
      m_v0  = rd;
      if (rd) m_d0 = q.pop_front();
      if (wr) q.push_back(din);
    end
  endtask

  task automatic check_all(string ph);
    int n;
    n = q.size();
    chk(ph, "count0", 64'(count0), 64'(n));
    chk(ph, "count1", 64'(count1), 64'(n));
    chk(ph, "empty0", 64'(empty0), 64'(n == 0));
    chk(ph, "empty1", 64'(empty1), 64'(n == 0));
    chk(ph, "full0",  64'(full0),  64'(n == 8));
    chk(ph, "full1",  64'(full1),  64'(n == 8));
    chk(ph, "aempty0", 64'(ae0), 64'(n <= 2));
    chk(ph, "aempty1", 64'(ae1), 64'(n <= 2));
    chk(ph, "afull0",  64'(af0), 64'(n >= 6));
    chk(ph, "afull1",  64'(af1), 64'(n >= 6));
    chk(ph, "ovf0", 64'(ovf0), 64'(m_ovf));
    chk(ph, "ovf1", 64'(ovf1), 64'(m_ovf));
    chk(ph, "unf0", 64'(unf0), 64'(m_unf));
    chk(ph, "unf1", 64'(unf1), 64'(m_unf));
    chk(ph, "valid0", 64'(valid0), 64'(m_v0));
    chk(ph, "dout0",  64'(dout0),  64'(m_d0));
    chk(ph, "valid1", 64'(valid1), 64'(n != 0));
    if (n != 0) chk(ph, "dout1", 64'(dout1), 64'(q[0]));
  endtask

  task automatic cyc(bit w, logic [31:0] d, bit r, bit fl, bit cl, string ph);
    we = w; din = d; re = r; flush = fl; clear_err = cl;
    @(posedge clk);
    m_step();
    #1;
    check_all(ph);
  endtask

  initial begin
    reset = 1; we = 0; re = 0; flush = 0; clear_err = 0; din = '0;
    m_reset();
    #3;
    check_all("reset");
    #4 reset = 0;

    // Fill with 0x11..0x88 then drain in order
    for (int i = 1; i <= 8; i++) cyc(1, 32'h11 * i, 0, 0, 0, "fill");
    for (int i = 1; i <= 8; i++) begin
      cyc(0, '0, 1, 0, 0, "drain");
      chk("drain", "dout_seq", 64'(dout0), 64'(32'h11 * i));
    end
    cyc(0, '0, 0, 0, 0, "idle");

    // Overflow while full with simultaneous read, then clear
    for (int i = 0; i < 8; i++) cyc(1, $urandom, 0, 0, 0, "fill2");
    cyc(1, 32'hDEAD, 1, 0, 0, "ovf_rw");
    chk("ovf_rw", "count_is_7", 64'(count0), 64'd7);
    cyc(0, '0, 0, 0, 1, "ovf_clr");
    for (int i = 0; i < 7; i++) cyc(0, '0, 1, 0, 0, "drain2");

    // Underflow on empty, then we+re on empty
    cyc(0, '0, 1, 0, 0, "unf");
    cyc(0, '0, 0, 0, 1, "unf_clr");
    cyc(1, $urandom, 1, 0, 0, "unf_wr");
    cyc(0, '0, 1, 0, 1, "unf_pop");

    // FWFT write into empty then pop
    cyc(1, 32'hA5, 0, 0, 0, "fwft_wr");
    cyc(0, '0, 0, 0, 0, "fwft_hold");
    chk("fwft_hold", "dout1_a5", 64'(dout1), 64'h0A5);
    cyc(0, '0, 1, 0, 0, "fwft_pop");

    // Steady state count=3 with wrapping pointers, then flush with we/re/clear
    cyc(0, '0, 1, 0, 0, "pre_unf");
    for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, 0, 0, "ss_fill");
    for (int i = 0; i < 20; i++) cyc(1, $urandom, 1, 0, 0, "ss_pair");
    cyc(1, 32'hBEEF, 1, 1, 1, "flush");
    cyc(0, '0, 0, 0, 1, "post_flush_clr");

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)),
          ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0), "rand");

    // Asynchronous reset between edges mid-burst
    for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0, 0, "burst");
    we = 1; din = 32'h77;
    #2 reset = 1;
    #1;
    m_reset();
    check_all("async_rst");
    we = 0; re = 0; flush = 0; clear_err = 0;
    #3 reset = 0;
    cyc(1, 32'h5A, 0, 0, 0, "post_rst_wr");
    cyc(0, '0, 1, 0, 0, "post_rst_rd");
    chk("post_rst_rd", "dout_5a", 64'(dout0), 64'h05A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flex_fifo.md
FLEX_FIFO -- requirements
Module: flex_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8: number of entries, a power of two >=2.
REQ-003 The block SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 The block SHALL have parameter AFULL_TH, default DEPTH-2: almost_full threshold, legal range 1..DEPTH.
REQ-005 The block SHALL have parameter AEMPTY_TH, default 2: almost_empty threshold, legal range 0..DEPTH-1.
REQ-006 The block SHALL have a single clock and an asynchronous, active-high reset; the ports SHALL be listed in the order below, where CW = log2(DEPTH)+1.
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- we  in  1  write request
- din  in  WIDTH  write data
- re  in  1  read request / pop
- flush  in  1  synchronous discard of all contents
- clear_err  in  1  clears sticky error flags
- dout  out  WIDTH  read data
- valid  out  1  dout qualifier
- empty  out  1  count==0
- full  out  1  count==DEPTH
- almost_empty  out  1  count<=AEMPTY_TH
- almost_full  out  1  count>=AFULL_TH
- count  out  CW  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

Function
REQ-007 A write SHALL be accepted iff we=1 and full=0 at the rising edge; din SHALL be stored at the write pointer, and the write pointer SHALL increment.
REQ-008 A read SHALL be accepted iff re=1 and empty=0 at the rising edge; the read pointer SHALL then increment.
REQ-009 Full and empty SHALL be evaluated on pre-edge state; when full, a simultaneous we+re SHALL accept only the read, and when empty it SHALL accept only the write.
REQ-010 The pointers SHALL be log2(DEPTH) bits wide and SHALL wrap DEPTH-1 -> 0 with no special handling.
REQ-011 count SHALL be +1 on write-only, -1 on read-only, and unchanged when both or neither are accepted; it SHALL never exceed DEPTH or go below 0.
REQ-012 empty, full, almost_empty and almost_full SHALL be registered and SHALL reflect the post-edge count in the same cycle that count updates.
REQ-013 When FWFT=0, an accepted read SHALL load dout with the head word one cycle after the re edge and pulse valid high for exactly that cycle; otherwise dout SHALL hold its last value and valid SHALL be 0.
REQ-014 When FWFT=1, dout SHALL present the head entry whenever empty=0, valid SHALL equal not-empty, and re with valid=1 SHALL pop the entry, presenting the next head (if any) the following cycle.
REQ-015 In FWFT mode, a write into an empty FIFO SHALL make valid=1 and dout=that word on the cycle after the write edge.
REQ-016 overflow SHALL set on any edge with we=1 and full=0-false (i.e. full=1), even if a read is accepted on the same edge.
REQ-017 underflow SHALL set on any edge with re=1 and empty=1.
REQ-018 overflow and underflow SHALL remain set until clear_err=1; if clear_err and a new error event occur on the same edge, the flag SHALL remain set.
REQ-019 flush=1 SHALL, on that edge, zero both pointers and count, set empty=1 and almost_empty=1, clear full and almost_full, and force valid=0.
REQ-020 During flush, we and re SHALL be ignored, no error flags SHALL be set, existing error flags SHALL be unchanged, and dout SHALL hold.
REQ-021 Storage contents SHALL NOT be reset and SHALL NOT be observable except via accepted reads.

Reset
REQ-022 While reset=1, independent of clk, outputs SHALL be: dout=0, valid=0, empty=1, full=0, almost_empty=1, almost_full=0, count=0, overflow=0, underflow=0.
REQ-023 While reset=1, both pointers SHALL be 0; reset asserted mid-operation SHALL discard all contents, and the first accepted write after release SHALL go to entry 0.

Verification
REQ-024 Scenario: defaults, FWFT=0; write 0x11..0x88 on 8 consecutive cycles -> count=8, full=1, almost_full=1 from count=6; then 8 reads -> dout 0x11..0x88 in order, each one cycle after re with valid pulse; empty=1 at end.
REQ-025 Scenario: full, we=1 and re=1 for one cycle -> read accepted, write dropped, count=7, overflow=1; then clear_err -> overflow=0.
REQ-026 Scenario: empty, re=1 -> underflow=1, count stays 0, valid=0; then we+re together on empty -> count=1, underflow set again.
REQ-027 Scenario: FWFT=1; write 0xA5 into empty -> next cycle valid=1, dout=0xA5 with no re; re=1 -> next cycle valid=0, empty=1.
REQ-028 Scenario: 20 write/read pairs at count=3 steady state -> pointers wrap, data in order, count constant 3; then flush with we=1 -> count=0, empty=1, write ignored, error flags unchanged.
REQ-029 Scenario: assert reset asynchronously mid-burst between clock edges -> all outputs take reset values immediately; after release, write 0x5A then read -> dout=0x5A.
